// File: rtl/mem_axi_pkg.sv
// Shared types and constants for the Rocket-to-PS AXI address window.
package mem_axi_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned ID_W   = 6;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_ERR  = 1'b1
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FWD  = 2'd1,
      W_SINK = 2'd2,
      W_ERRB = 2'd3
   } wr_state_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic              lock;
      logic [3:0]        cache;
      logic [2:0]        prot;
      logic [3:0]        qos;
   } axi_addr_t;

endpackage

// File: rtl/axi_addr_slice.sv
// One-entry AR/AW output register; the owner decides when to push.
module axi_addr_slice
   import mem_axi_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      push,
   input  axi_addr_t in_data,
   output logic      can_accept,
   output logic      empty,
   output logic      out_valid,
   input  logic      out_ready,
   output axi_addr_t out_data
);

   logic      full;
   axi_addr_t data_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         full <= 1'b0;
      end else if (push) begin
         full <= 1'b1;
      end else if (out_ready) begin
         full <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         data_q <= in_data;
      end
   end

   // A push while the held entry drains keeps full throughput.
   assign can_accept = !full || out_ready;
   assign empty      = !full;
   assign out_valid  = full;
   assign out_data   = data_q;

endmodule

// File: rtl/mem_axi_window.sv
// Relocates in-window AXI traffic into the Rocket DRAM region and answers
// out-of-window requests locally with DECERR instead of aliasing them.
module mem_axi_window
   import mem_axi_pkg::*;
#(
   parameter int unsigned       DATA_W   = 64,
   parameter int unsigned       WIN_BITS = 28,
   parameter logic [ADDR_W-1:0] BASE     = 32'h1000_0000,
   parameter int unsigned       MAX_OUT  = 15
) (
   input  logic                clock,
   input  logic                reset,
   // upstream (Top) AW/W/B
   input  logic                s_aw_valid,
   output logic                s_aw_ready,
   input  logic [ID_W-1:0]     s_aw_id,
   input  logic [ADDR_W-1:0]   s_aw_addr,
   input  logic [7:0]          s_aw_len,
   input  logic [2:0]          s_aw_size,
   input  logic [1:0]          s_aw_burst,
   input  logic                s_aw_lock,
   input  logic [3:0]          s_aw_cache,
   input  logic [2:0]          s_aw_prot,
   input  logic [3:0]          s_aw_qos,
   input  logic                s_w_valid,
   output logic                s_w_ready,
   input  logic [DATA_W-1:0]   s_w_data,
   input  logic [DATA_W/8-1:0] s_w_strb,
   input  logic                s_w_last,
   output logic                s_b_valid,
   input  logic                s_b_ready,
   output logic [ID_W-1:0]     s_b_id,
   output logic [1:0]          s_b_resp,
   // upstream (Top) AR/R
   input  logic                s_ar_valid,
   output logic                s_ar_ready,
   input  logic [ID_W-1:0]     s_ar_id,
   input  logic [ADDR_W-1:0]   s_ar_addr,
   input  logic [7:0]          s_ar_len,
   input  logic [2:0]          s_ar_size,
   input  logic [1:0]          s_ar_burst,
   input  logic                s_ar_lock,
   input  logic [3:0]          s_ar_cache,
   input  logic [2:0]          s_ar_prot,
   input  logic [3:0]          s_ar_qos,
   output logic                s_r_valid,
   input  logic                s_r_ready,
   output logic [ID_W-1:0]     s_r_id,
   output logic [DATA_W-1:0]   s_r_data,
   output logic [1:0]          s_r_resp,
   output logic                s_r_last,
   // downstream (PS HP) AW/W/B
   output logic                m_aw_valid,
   input  logic                m_aw_ready,
   output logic [ID_W-1:0]     m_aw_id,
   output logic [ADDR_W-1:0]   m_aw_addr,
   output logic [7:0]          m_aw_len,
   output logic [2:0]          m_aw_size,
   output logic [1:0]          m_aw_burst,
   output logic                m_aw_lock,
   output logic [3:0]          m_aw_cache,
   output logic [2:0]          m_aw_prot,
   output logic [3:0]          m_aw_qos,
   output logic                m_w_valid,
   input  logic                m_w_ready,
   output logic [DATA_W-1:0]   m_w_data,
   output logic [DATA_W/8-1:0] m_w_strb,
   output logic                m_w_last,
   input  logic                m_b_valid,
   output logic                m_b_ready,
   input  logic [ID_W-1:0]     m_b_id,
   input  logic [1:0]          m_b_resp,
   // downstream (PS HP) AR/R
   output logic                m_ar_valid,
   input  logic                m_ar_ready,
   output logic [ID_W-1:0]     m_ar_id,
   output logic [ADDR_W-1:0]   m_ar_addr,
   output logic [7:0]          m_ar_len,
   output logic [2:0]          m_ar_size,
   output logic [1:0]          m_ar_burst,
   output logic                m_ar_lock,
   output logic [3:0]          m_ar_cache,
   output logic [2:0]          m_ar_prot,
   output logic [3:0]          m_ar_qos,
   input  logic                m_r_valid,
   output logic                m_r_ready,
   input  logic [ID_W-1:0]     m_r_id,
   input  logic [DATA_W-1:0]   m_r_data,
   input  logic [1:0]          m_r_resp,
   input  logic                m_r_last
);

   localparam int unsigned CNT_W = 4;

   // ------------------------------------------------------------------
   // Address slices
   // ------------------------------------------------------------------
   axi_addr_t ar_in, ar_out, aw_in, aw_out;
   logic      ar_push, ar_can_accept, ar_empty;
   logic      aw_push, aw_can_accept, aw_empty;
   logic      ar_in_win, aw_in_win;

   assign ar_in_win = (s_ar_addr[ADDR_W-1:WIN_BITS] == '0);
   assign aw_in_win = (s_aw_addr[ADDR_W-1:WIN_BITS] == '0);

   always_comb begin
      ar_in       = '0;
      ar_in.id    = s_ar_id;
      ar_in.addr  = BASE | ADDR_W'(s_ar_addr[WIN_BITS-1:0]);
      ar_in.len   = s_ar_len;
      ar_in.size  = s_ar_size;
      ar_in.burst = s_ar_burst;
      ar_in.lock  = s_ar_lock;
      ar_in.cache = s_ar_cache;
      ar_in.prot  = s_ar_prot;
      ar_in.qos   = s_ar_qos;
      aw_in       = '0;
      aw_in.id    = s_aw_id;
      aw_in.addr  = BASE | ADDR_W'(s_aw_addr[WIN_BITS-1:0]);
      aw_in.len   = s_aw_len;
      aw_in.size  = s_aw_size;
      aw_in.burst = s_aw_burst;
      aw_in.lock  = s_aw_lock;
      aw_in.cache = s_aw_cache;
      aw_in.prot  = s_aw_prot;
      aw_in.qos   = s_aw_qos;
   end

   axi_addr_slice u_ar_slice (
      .clock      (clock),
      .reset      (reset),
      .push       (ar_push),
      .in_data    (ar_in),
      .can_accept (ar_can_accept),
      .empty      (ar_empty),
      .out_valid  (m_ar_valid),
      .out_ready  (m_ar_ready),
      .out_data   (ar_out)
   );

   axi_addr_slice u_aw_slice (
      .clock      (clock),
      .reset      (reset),
      .push       (aw_push),
      .in_data    (aw_in),
      .can_accept (aw_can_accept),
      .empty      (aw_empty),
      .out_valid  (m_aw_valid),
      .out_ready  (m_aw_ready),
      .out_data   (aw_out)
   );

   assign m_ar_id    = ar_out.id;
   assign m_ar_addr  = ar_out.addr;
   assign m_ar_len   = ar_out.len;
   assign m_ar_size  = ar_out.size;
   assign m_ar_burst = ar_out.burst;
   assign m_ar_lock  = ar_out.lock;
   assign m_ar_cache = ar_out.cache;
   assign m_ar_prot  = ar_out.prot;
   assign m_ar_qos   = ar_out.qos;

   assign m_aw_id    = aw_out.id;
   assign m_aw_addr  = aw_out.addr;
   assign m_aw_len   = aw_out.len;
   assign m_aw_size  = aw_out.size;
   assign m_aw_burst = aw_out.burst;
   assign m_aw_lock  = aw_out.lock;
   assign m_aw_cache = aw_out.cache;
   assign m_aw_prot  = aw_out.prot;
   assign m_aw_qos   = aw_out.qos;

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   rd_state_t        rd_state, rd_state_nx;
   logic [CNT_W-1:0] rd_out;
   logic [ID_W-1:0]  rd_err_id;
   logic [7:0]       rd_err_left;
   logic             ar_take_err, rd_dec;

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_state    <= R_IDLE;
         rd_out      <= '0;
         rd_err_id   <= '0;
         rd_err_left <= '0;
      end else begin
         rd_state <= rd_state_nx;
         unique case ({ar_push, rd_dec})
            2'b10:   rd_out <= rd_out + CNT_W'(1);
            2'b01:   rd_out <= rd_out - CNT_W'(1);
            default: ;
         endcase
         if (ar_take_err) begin
            rd_err_id   <= s_ar_id;
            rd_err_left <= s_ar_len;
         end else if (rd_state == R_ERR && s_r_ready && rd_err_left != 8'd0) begin
            rd_err_left <= rd_err_left - 8'd1;
         end
      end
   end

   always_comb begin
      rd_state_nx = rd_state;
      s_ar_ready  = 1'b0;
      ar_push     = 1'b0;
      ar_take_err = 1'b0;
      s_r_valid   = m_r_valid;
      s_r_id      = m_r_id;
      s_r_data    = m_r_data;
      s_r_resp    = m_r_resp;
      s_r_last    = m_r_last;
      m_r_ready   = s_r_ready;
      unique case (rd_state)
         R_IDLE: begin
            // Out-of-window waits for a drained path so DECERR keeps R order.
            if (ar_in_win) begin
               s_ar_ready = (rd_out < CNT_W'(MAX_OUT)) && ar_can_accept;
               ar_push    = s_ar_valid && s_ar_ready;
            end else begin
               s_ar_ready  = (rd_out == '0) && ar_empty;
               ar_take_err = s_ar_valid && s_ar_ready;
               if (ar_take_err) begin
                  rd_state_nx = R_ERR;
               end
            end
         end
         R_ERR: begin
            s_r_valid = 1'b1;
            s_r_id    = rd_err_id;
            s_r_data  = '0;
            s_r_resp  = RESP_DECERR;
            s_r_last  = (rd_err_left == 8'd0);
            m_r_ready = 1'b0;
            if (s_r_ready && s_r_last) begin
               rd_state_nx = R_IDLE;
            end
         end
         default: rd_state_nx = R_IDLE;
      endcase
   end

   assign rd_dec = m_r_valid && m_r_ready && m_r_last;

   // ------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------
   wr_state_t        wr_state, wr_state_nx;
   logic [CNT_W-1:0] wr_out;
   logic [ID_W-1:0]  wr_err_id;
   logic             aw_take_err, wr_dec;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_state  <= W_IDLE;
         wr_out    <= '0;
         wr_err_id <= '0;
      end else begin
         wr_state <= wr_state_nx;
         unique case ({aw_push, wr_dec})
            2'b10:   wr_out <= wr_out + CNT_W'(1);
            2'b01:   wr_out <= wr_out - CNT_W'(1);
            default: ;
         endcase
         if (aw_take_err) begin
            wr_err_id <= s_aw_id;
         end
      end
   end

   assign m_w_data = s_w_data;
   assign m_w_strb = s_w_strb;
   assign m_w_last = s_w_last;

   always_comb begin
      wr_state_nx = wr_state;
      s_aw_ready  = 1'b0;
      aw_push     = 1'b0;
      aw_take_err = 1'b0;
      s_w_ready   = 1'b0;
      m_w_valid   = 1'b0;
      s_b_valid   = m_b_valid;
      s_b_id      = m_b_id;
      s_b_resp    = m_b_resp;
      m_b_ready   = s_b_ready;
      unique case (wr_state)
         W_IDLE: begin
            if (aw_in_win) begin
               s_aw_ready = (wr_out < CNT_W'(MAX_OUT)) && aw_can_accept;
               aw_push    = s_aw_valid && s_aw_ready;
               if (aw_push) begin
                  wr_state_nx = W_FWD;
               end
            end else begin
               s_aw_ready  = (wr_out == '0) && aw_empty;
               aw_take_err = s_aw_valid && s_aw_ready;
               if (aw_take_err) begin
                  wr_state_nx = W_SINK;
               end
            end
         end
         W_FWD: begin
            m_w_valid = s_w_valid;
            s_w_ready = m_w_ready;
            if (s_w_valid && m_w_ready && s_w_last) begin
               wr_state_nx = W_IDLE;
            end
         end
         W_SINK: begin
            s_w_ready = 1'b1;
            if (s_w_valid && s_w_last) begin
               wr_state_nx = W_ERRB;
            end
         end
         W_ERRB: begin
            s_b_valid = 1'b1;
            s_b_id    = wr_err_id;
            s_b_resp  = RESP_DECERR;
            m_b_ready = 1'b0;
            if (s_b_ready) begin
               wr_state_nx = W_IDLE;
            end
         end
         default: wr_state_nx = W_IDLE;
      endcase
   end

   assign wr_dec = m_b_valid && m_b_ready;

endmodule

// File: doc/mem_axi_window.md
# mem_axi_window

AXI4 address-window stage between the Rocket `Top` memory port (`io_mem_axi_*`) and the PS HP slave port (`S_AXI_*`). It replaces the bare `{4'd1, addr[27:0]}` rewrite, which silently aliases out-of-range addresses. The block relocates in-window requests into the DRAM region given to Rocket, registers the AR/AW channels, and answers out-of-window requests locally with DECERR instead of aliasing them into DRAM.

## Interface
- `ADDR_W`, 32: address width, both sides.
- `DATA_W`, 64: R/W data width; `STRB_W = DATA_W/8`.
- `ID_W`, 6: AXI ID width.
- `WIN_BITS`, 28: window size is 2^WIN_BITS bytes; requests with `addr[ADDR_W-1:WIN_BITS] != 0` are out-of-window.
- `BASE`, 32'h1000_0000: DRAM base the window is relocated to; `BASE[WIN_BITS-1:0]` must be 0.
- `MAX_OUT`, 15: maximum forwarded bursts in flight per direction; counters are 4 bits.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `s_aw_{valid,id,addr,len,size,burst,lock,cache,prot,qos}` in; `s_aw_ready` out: AW from Top.
- `s_w_{valid,data,strb,last}` in; `s_w_ready` out.
- `s_b_{valid,id,resp}` out; `s_b_ready` in.
- `s_ar_{valid,id,addr,len,size,burst,lock,cache,prot,qos}` in; `s_ar_ready` out.
- `s_r_{valid,id,data,resp,last}` out; `s_r_ready` in.
- `m_aw_*`, `m_w_*`, `m_b_*`, `m_ar_*`, `m_r_*`: the same bundles toward the PS, with directions mirrored.

## Operation
- Remap: `m_addr = BASE | s_addr[WIN_BITS-1:0]`. All other AR/AW fields pass through unchanged.
- AR/AW each use a 1-entry output register. Accept when the register is empty or `m_x_ready` is high. `m_x_valid` is driven only from the register.
- Read FSM:
  - R_IDLE: on `s_ar_valid`:
    - in-window: accept if `rd_out < MAX_OUT`, load the register, `rd_out++`.
    - out-of-window: accept only if `rd_out == 0` and the register is empty. Latch id/len, go to R_ERR.
  - R_ERR: drive `len+1` beats with `s_r_resp=2'b11`, `data=0`, the latched id, and `last` on the final beat. Hold `m_r_ready=0`. Return to R_IDLE after the final beat handshakes. No AR is accepted while in R_ERR.
  - In R_IDLE, `m_r_*` is routed to `s_r_*` combinationally. `rd_out--` on an `m_r` handshake with `last`.
- Write FSM:
  - W_IDLE: accept AW as for AR, using `wr_out` for the in-window check and `wr_out == 0` for out-of-window.
    - in-window → W_FWD, `wr_out++`.
    - out-of-window → W_SINK.
  - W_FWD: route W to `m_w_*` combinationally. On the `wlast` handshake → W_IDLE.
  - W_SINK: `s_w_ready=1`, `m_w_valid=0`. On the `wlast` handshake → W_ERRB.
  - W_ERRB: `s_b_valid=1`, resp DECERR, latched id. On handshake → W_IDLE.
  - Outside W_ERRB, `m_b_*` is routed to `s_b_*`. `wr_out--` on an `m_b` handshake.
- W beats arriving before their AW are not accepted: `s_w_ready=0` in W_IDLE.
- Simultaneous increment and decrement of `rd_out`/`wr_out` in one cycle leaves the counter unchanged.
- Reset outputs: all `*_valid` = 0, counters = 0, both FSMs IDLE, address registers empty.
- Reset mid-burst abandons all in-flight state. Recovery of the downstream port is the system reset's responsibility.

## Timing
- AR/AW forwarding latency: 1 cycle from the `s` handshake to `m_x_valid`. Full throughput holds when `m_x_ready` stays high.
- W, R, B forward paths: 0-cycle combinational pass-through.
- DECERR read: first beat appears 1 cycle after AR acceptance; one beat per cycle while `s_r_ready` is high.
- DECERR write: B appears 1 cycle after the `wlast` handshake.
- Valid/payload on every output is held stable until ready (AXI rule). The local responders never drop valid.

## Structure
- Package `mem_axi_pkg`: `RESP_OKAY`/`RESP_DECERR` constants, `rd_state_t`/`wr_state_t` enums, and an `axi_addr_t` struct (id, addr, len, size, burst, lock, cache, prot, qos).
- Sub-module `axi_addr_slice`: the 1-entry address register, instantiated twice (AR and AW). The FSMs and counters live in the top module.

## Test plan
- Remap: read id=5, addr 0x0123_4560, len 0 → `m_ar_addr` 0x1123_4560 one cycle later. The R beat returns to `s_r` with id 5, OKAY, last.
- Out-of-window read: addr 0x1000_0000, len 3, id 2 → 4 `s_r` beats, resp 2'b11, data 0, id 2, last only on beat 4. `m_ar_valid` never asserts.
- Out-of-window write: addr 0xF000_0000, len 1 → 2 W beats sunk with `m_w_valid=0`, then one `s_b` with DECERR and the AW id.
- Outstanding limit:
  - 16 back-to-back in-window reads with `m_r_valid` held 0 → exactly 15 accepted and `s_ar_ready` low on the 16th.
  - One `m_r` last beat → 16th accepted next cycle.
- Ordering: out-of-window AR issued while 2 reads are outstanding → not accepted until `rd_out` reaches 0. Then the DECERR beats follow the last forwarded R.
- Reset mid-operation: `reset` asserted during R_ERR beat 2 of 4 → next cycle all valids 0, counters 0, FSMs IDLE. A new in-window read then completes normally.
